// File: rtl/des_key_sched.sv
// DES key schedule: expands a post-PC-1 56-bit key into K1..K16, one subkey per
// accepted valid/ready beat. Optional reverse (decrypt) order under KEY_SCHED_DECRYPT_EN.
module des_key_sched #(
  parameter int NROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [55:0] key,
  input  logic        start,
`ifdef KEY_SCHED_DECRYPT_EN
  input  logic        decrypt,
`endif
  output logic        busy,
  output logic [47:0] subkey,
  output logic [3:0]  subkey_idx,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic        subkey_last
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [3:0] LAST_IDX = 4'(NROUNDS - 1);

  // Per-round left-rotate amounts; entry n is the shift applied to produce round n+1.
  localparam logic [1:0] SHIFT [16] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

  // PC-2 in DES numbering: bit 1 is the MSB of {C,D}.
  localparam int PC2_TAB [48] = '{14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
                                  23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
                                  41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                                  44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
    return (n == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
    return (n == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] out;
    out = 48'd0;
    for (int i = 0; i < 48; i++) begin
      out[47-i] = cd[56-PC2_TAB[i]];
    end
    return out;
  endfunction

  state_t      state_q, state_d;
  logic [27:0] c_half_q, c_half_d;
  logic [27:0] d_half_q, d_half_d;
  logic [3:0]  idx_q, idx_d;
  logic        dec_q, dec_d;
  logic        start_dec_s;

`ifdef KEY_SCHED_DECRYPT_EN
  assign start_dec_s = decrypt;
`else
  assign start_dec_s = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    c_half_d = c_half_q;
    d_half_d = d_half_q;
    idx_d    = idx_q;
    dec_d    = dec_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          dec_d   = start_dec_s;
          if (start_dec_s) begin
            // Total rotation over a run is 28, so the unrotated halves are C16/D16.
            c_half_d = key[55:28];
            d_half_d = key[27:0];
            idx_d    = LAST_IDX;
          end else begin
            c_half_d = rotl28(key[55:28], SHIFT[0]);
            d_half_d = rotl28(key[27:0], SHIFT[0]);
            idx_d    = 4'd0;
          end
        end
      end
      RUN: begin
        if (subkey_ready) begin
          if (dec_q) begin
            if (idx_q == 4'd0) begin
              state_d = IDLE;
            end else begin
              c_half_d = rotr28(c_half_q, SHIFT[idx_q]);
              d_half_d = rotr28(d_half_q, SHIFT[idx_q]);
              idx_d    = idx_q - 4'd1;
            end
          end else begin
            if (idx_q == LAST_IDX) begin
              state_d = IDLE;
            end else begin
              c_half_d = rotl28(c_half_q, SHIFT[idx_q + 4'd1]);
              d_half_d = rotl28(d_half_q, SHIFT[idx_q + 4'd1]);
              idx_d    = idx_q + 4'd1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      c_half_q <= 28'd0;
      d_half_q <= 28'd0;
      idx_q    <= 4'd0;
      dec_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      c_half_q <= c_half_d;
      d_half_q <= d_half_d;
      idx_q    <= idx_d;
      dec_q    <= dec_d;
    end
  end

  assign busy         = (state_q == RUN);
  assign subkey_valid = (state_q == RUN);
  assign subkey_idx   = idx_q;
  assign subkey       = subkey_valid ? pc2({c_half_q, d_half_q}) : 48'd0;
  assign subkey_last  = subkey_valid && (dec_q ? (idx_q == 4'd0) : (idx_q == LAST_IDX));

endmodule

// File: tb/tb_des_key_sched.sv
// Self-checking bench for des_key_sched: scoreboard of expected subkeys built from
// an independent DES key-schedule model, plus known-answer constants.
module tb_des_key_sched;

  localparam logic [55:0] KNOWN_KEY = 56'hF0CCAAF556678F;
  localparam logic [47:0] KA_K1  = 48'h1B02EFFC7072;
  localparam logic [47:0] KA_K2  = 48'h79AED9DBC9E5;
  localparam logic [47:0] KA_K16 = 48'hCB3D8B0E17F5;

  localparam int SCHED [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam int PC2 [48] = '{14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
                              23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
                              41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                              44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  typedef struct packed {
    logic [47:0] sk;
    logic [3:0]  idx;
    logic        last;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [55:0] key;
  logic        start;
  logic        decrypt;
  logic        busy;
  logic [47:0] subkey;
  logic [3:0]  subkey_idx;
  logic        subkey_valid;
  logic        subkey_ready;
  logic        subkey_last;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  des_key_sched dut (
    .clk         (clk),
    .rst         (rst),
    .key         (key),
    .start       (start),
`ifdef KEY_SCHED_DECRYPT_EN
    .decrypt     (decrypt),
`endif
    .busy        (busy),
    .subkey      (subkey),
    .subkey_idx  (subkey_idx),
    .subkey_valid(subkey_valid),
    .subkey_ready(subkey_ready),
    .subkey_last (subkey_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Round r (1..16): rotate both halves by the cumulative shift, then PC-2.
  function automatic logic [47:0] model_key(input logic [55:0] k, input int round);
    logic [27:0] c, d;
    logic [55:0] cd;
    logic [47:0] out;
    int tot;
    tot = 0;
    for (int r = 0; r < round; r++) tot += SCHED[r];
    c = k[55:28];
    d = k[27:0];
    for (int s = 0; s < tot; s++) begin
      c = {c[26:0], c[27]};
      d = {d[26:0], d[27]};
    end
    cd = {c, d};
    out = 48'd0;
    for (int i = 0; i < 48; i++) out[47-i] = cd[56-PC2[i]];
    return out;
  endfunction

  task automatic push_run(input logic [55:0] k, input logic rev);
    exp_t x;
    for (int n = 0; n < 16; n++) begin
      x.sk   = model_key(k, rev ? 16 - n : n + 1);
      x.idx  = rev ? 4'(15 - n) : 4'(n);
      x.last = (n == 15);
      sb.push_back(x);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b1; key = KNOWN_KEY;
    step(); step();
    checks++;
    if (busy !== 1'b0 || subkey_valid !== 1'b0 || subkey !== 48'd0) begin
      errors++;
      $display("FAIL reset: busy=%b valid=%b subkey=%h, expected 0/0/0", busy, subkey_valid, subkey);
    end
    rst = 1'b1; start = 1'b0;
    step();
    checks++;
    if (subkey_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_run: valid=%b busy=%b, expected 0/0", subkey_valid, busy);
    end
  endtask

  task automatic test_known_answer();
    key = KNOWN_KEY; start = 1'b1; subkey_ready = 1'b1;
    push_run(KNOWN_KEY, 1'b0);
    step();
    start = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      checks++;
      if (subkey_valid !== 1'b1 || sb.size() == 0) begin
        errors++;
        $display("FAIL ka_valid: cycle %0d valid=%b queued=%0d, expected valid=1", c, subkey_valid, sb.size());
      end else begin
        e = sb.pop_front();
        if (subkey !== e.sk || subkey_idx !== e.idx || subkey_last !== e.last) begin
          errors++;
          $display("FAIL ka_seq: subkey=%h idx=%0d last=%b, expected %h idx=%0d last=%b",
                   subkey, subkey_idx, subkey_last, e.sk, e.idx, e.last);
        end
      end
      if (c == 1 || c == 2 || c == 16) begin
        checks++;
        if (subkey !== ((c == 1) ? KA_K1 : (c == 2) ? KA_K2 : KA_K16)) begin
          errors++;
          $display("FAIL ka_const: cycle %0d subkey=%h, expected %h", c, subkey,
                   (c == 1) ? KA_K1 : (c == 2) ? KA_K2 : KA_K16);
        end
      end
      step();
    end
    checks++;
    if (subkey_valid !== 1'b0 || busy !== 1'b0 || subkey_last !== 1'b0 || subkey !== 48'd0) begin
      errors++;
      $display("FAIL ka_end: valid=%b busy=%b last=%b subkey=%h, expected all 0",
               subkey_valid, busy, subkey_last, subkey);
    end
  endtask

  task automatic test_backpressure();
    key = KNOWN_KEY; start = 1'b1; subkey_ready = 1'b1;
    push_run(KNOWN_KEY, 1'b0);
    step();
    start = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      subkey_ready = !(c >= 2 && c <= 6);
      checks++;
      if (subkey_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_valid: cycle %0d valid=%b, expected 1", c, subkey_valid);
      end
      if (c >= 2 && c <= 7) begin
        checks++;
        if (subkey !== KA_K2 || subkey_idx !== 4'd1) begin
          errors++;
          $display("FAIL bp_hold: cycle %0d subkey=%h idx=%0d, expected %h idx=1", c, subkey, subkey_idx, KA_K2);
        end
      end
      if (subkey_valid && subkey_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL bp_extra: unexpected subkey %h idx=%0d, expected none", subkey, subkey_idx);
        end else begin
          e = sb.pop_front();
          if (subkey !== e.sk || subkey_idx !== e.idx || subkey_last !== e.last) begin
            errors++;
            $display("FAIL bp_seq: subkey=%h idx=%0d last=%b, expected %h idx=%0d last=%b",
                     subkey, subkey_idx, subkey_last, e.sk, e.idx, e.last);
          end
        end
      end
      step();
    end
    subkey_ready = 1'b1;
    checks++;
    if (subkey_valid !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL bp_end: valid=%b left=%0d, expected valid=0 left=0", subkey_valid, sb.size());
    end
  endtask

  task automatic test_ignored_start();
    key = KNOWN_KEY; start = 1'b1; subkey_ready = 1'b1;
    push_run(KNOWN_KEY, 1'b0);
    step();
    start = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      checks++;
      if (subkey_valid !== 1'b1 || sb.size() == 0) begin
        errors++;
        $display("FAIL ign_valid: cycle %0d valid=%b, expected 1", c, subkey_valid);
      end else begin
        e = sb.pop_front();
        if (subkey !== e.sk || subkey_idx !== e.idx || subkey_last !== e.last) begin
          errors++;
          $display("FAIL ign_seq: subkey=%h idx=%0d last=%b, expected %h idx=%0d last=%b",
                   subkey, subkey_idx, subkey_last, e.sk, e.idx, e.last);
        end
      end
      if (c == 5) begin
        start = 1'b1;
        key = 56'h0;
      end else if (c == 6) begin
        start = 1'b0;
      end else if (c == 16) begin
        start = 1'b1;
      end
      step();
    end
    checks++;
    if (subkey_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ign_last_start: valid=%b busy=%b, expected 0/0", subkey_valid, busy);
    end
    push_run(56'h0, 1'b0);
    step();
    start = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      checks++;
      if (subkey_valid !== 1'b1 || sb.size() == 0) begin
        errors++;
        $display("FAIL zero_valid: cycle %0d valid=%b, expected 1", c, subkey_valid);
      end else begin
        e = sb.pop_front();
        if (subkey !== e.sk || subkey !== 48'd0 || subkey_idx !== e.idx || subkey_last !== e.last) begin
          errors++;
          $display("FAIL zero_seq: subkey=%h idx=%0d last=%b, expected %h idx=%0d last=%b",
                   subkey, subkey_idx, subkey_last, e.sk, e.idx, e.last);
        end
      end
      step();
    end
    checks++;
    if (subkey_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_end: valid=%b, expected 0", subkey_valid);
    end
  endtask

  task automatic test_mid_run_reset();
    key = KNOWN_KEY; start = 1'b1; subkey_ready = 1'b1;
    push_run(KNOWN_KEY, 1'b0);
    step();
    start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      checks++;
      e = sb.pop_front();
      if (subkey_valid !== 1'b1 || subkey !== e.sk || subkey_idx !== e.idx) begin
        errors++;
        $display("FAIL mr_seq: valid=%b subkey=%h idx=%0d, expected 1 %h idx=%0d",
                 subkey_valid, subkey, subkey_idx, e.sk, e.idx);
      end
      step();
    end
    checks++;
    if (subkey_idx !== 4'd7 || subkey !== sb[0].sk) begin
      errors++;
      $display("FAIL mr_idx7: subkey=%h idx=%0d, expected %h idx=7", subkey, subkey_idx, sb[0].sk);
    end
    sb.delete();
    rst = 1'b0;
    step();
    checks++;
    if (subkey_valid !== 1'b0 || busy !== 1'b0 || subkey !== 48'd0) begin
      errors++;
      $display("FAIL mr_reset: valid=%b busy=%b subkey=%h, expected 0/0/0", subkey_valid, busy, subkey);
    end
    rst = 1'b1;
    step();
    checks++;
    if (subkey_valid !== 1'b0) begin
      errors++;
      $display("FAIL mr_after: valid=%b, expected 0", subkey_valid);
    end
    start = 1'b1;
    push_run(KNOWN_KEY, 1'b0);
    step();
    start = 1'b0;
    checks++;
    if (subkey_valid !== 1'b1 || subkey !== KA_K1 || subkey_idx !== 4'd0) begin
      errors++;
      $display("FAIL mr_restart: valid=%b subkey=%h idx=%0d, expected 1 %h idx=0",
               subkey_valid, subkey, subkey_idx, KA_K1);
    end
    for (int c = 1; c <= 16; c++) begin
      e = sb.pop_front();
      step();
    end
    checks++;
    if (subkey_valid !== 1'b0) begin
      errors++;
      $display("FAIL mr_end: valid=%b, expected 0", subkey_valid);
    end
  endtask

`ifdef KEY_SCHED_DECRYPT_EN
  task automatic test_decrypt();
    key = KNOWN_KEY; start = 1'b1; decrypt = 1'b1; subkey_ready = 1'b1;
    push_run(KNOWN_KEY, 1'b1);
    step();
    start = 1'b0; decrypt = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      checks++;
      if (subkey_valid !== 1'b1 || sb.size() == 0) begin
        errors++;
        $display("FAIL dec_valid: cycle %0d valid=%b, expected 1", c, subkey_valid);
      end else begin
        e = sb.pop_front();
        if (subkey !== e.sk || subkey_idx !== e.idx || subkey_last !== e.last) begin
          errors++;
          $display("FAIL dec_seq: subkey=%h idx=%0d last=%b, expected %h idx=%0d last=%b",
                   subkey, subkey_idx, subkey_last, e.sk, e.idx, e.last);
        end
      end
      if (c == 1 || c == 16) begin
        checks++;
        if (subkey !== ((c == 1) ? KA_K16 : KA_K1)) begin
          errors++;
          $display("FAIL dec_const: cycle %0d subkey=%h, expected %h", c, subkey, (c == 1) ? KA_K16 : KA_K1);
        end
      end
      step();
    end
    checks++;
    if (subkey_valid !== 1'b0) begin
      errors++;
      $display("FAIL dec_end: valid=%b, expected 0", subkey_valid);
    end
  endtask
`endif

  initial begin
    rst = 1'b0; start = 1'b0; key = 56'h0; decrypt = 1'b0; subkey_ready = 1'b1;
    test_reset();
    test_known_answer();
    step();
    test_backpressure();
    step();
    test_ignored_start();
    step();
    test_mid_run_reset();
`ifdef KEY_SCHED_DECRYPT_EN
    step();
    test_decrypt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
